varredura_matriz: RTL



---
 rtl/varredura_matriz_pkg.sv | 25 ++
 rtl/varredura_matriz_if.sv | 31 +++
 rtl/varredura_matriz_contador_slot.sv | 40 ++++
 rtl/varredura_matriz.sv | 119 +++++++++++
 4 files changed

// File: rtl/varredura_matriz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_matriz_pkg
//  Description : Shared constants, scan state encoding and frame index helper
//                for the 6x6 LED matrix row-scan driver and frame encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package varredura_matriz_pkg;

  localparam int LINHAS  = 6;
  localparam int COLUNAS = 6;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    APAGADO = 2'd1,
    ACESO   = 2'd2
  } estado_t;

  // Flat frame bit position of row r, column c.
  function automatic logic [5:0] indice(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'd6 + 6'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/varredura_matriz_if.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_matriz_if
//  Description : Frame input and matrix pin bundle of the row-scan driver.
//                master = game/frame side, slave = scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface varredura_matriz_if;
  logic        enable;
  logic [35:0] leds;
  logic [5:0]  linhas;
  logic [5:0]  colunas;
  logic        fim_quadro;

  modport master (
    output enable,
    output leds,
    input  linhas,
    input  colunas,
    input  fim_quadro
  );

  modport slave (
    input  enable,
    input  leds,
    output linhas,
    output colunas,
    output fim_quadro
  );
endinterface
`default_nettype wire

// File: rtl/varredura_matriz_contador_slot.sv
`default_nettype none
// ============================================================================
//  Module      : contador_slot
//  Description : Row-slot prescaler. Counts 0..DIV_CICLOS-1 while i_conta is
//                high, holds at 0 otherwise; o_tc flags the last slot cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_slot #(
  parameter int DIV_CICLOS = 50000
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          i_conta,
  output logic [$clog2(DIV_CICLOS)-1:0]      o_cnt,
  output logic                               o_tc
);

  localparam int                 c_W      = $clog2(DIV_CICLOS);
  localparam logic [c_W-1:0]     c_ULTIMO = c_W'(DIV_CICLOS - 1);

  logic [c_W-1:0] r_cnt;
  logic           w_tc;

  assign w_tc  = (r_cnt == c_ULTIMO);
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  // Slot cycle counter: cleared when idle, wraps at the end of each slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_conta || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/varredura_matriz.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_matriz
//  Description : Row-scan driver for the 6x6 LED matrix. Latches the 36-bit
//                frame at each row-0 entry and drives one-hot rows and column
//                data with a blanking window at the start of every row slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module varredura_matriz
  import varredura_matriz_pkg::*;
#(
  parameter int DIV_CICLOS   = 50000,
  parameter int BLANK_CICLOS = 16
) (
  input  wire logic         clock,
  input  wire logic         reset,
  varredura_matriz_if.slave bus
);

  localparam int              c_W            = $clog2(DIV_CICLOS);
  // Blank window ends when the slot counter reaches this value.
  localparam logic [c_W-1:0]  c_BLANK_FIM    = (BLANK_CICLOS > 0) ? c_W'(BLANK_CICLOS - 1) : '0;
  // First state of every slot; with no blanking a slot starts lit.
  localparam estado_t         c_INICIO       = (BLANK_CICLOS == 0) ? ACESO : APAGADO;
  localparam logic [2:0]      c_ULTIMA_LINHA = 3'(LINHAS - 1);

  estado_t        r_estado;
  estado_t        w_estado_prox;
  logic [c_W-1:0] w_cnt;
  logic           w_tc;
  logic [2:0]     r_lin;
  logic [35:0]    r_quadro;
  logic           w_rodando;
  logic           w_conta;
  logic           w_ultima;

  assign w_rodando = (r_estado != PARADO);
  // Counter only advances inside a running scan; the enable edge itself
  // leaves it at 0 so the first slot gets its full length.
  assign w_conta   = w_rodando & bus.enable;
  assign w_ultima  = (r_lin == c_ULTIMA_LINHA);

  contador_slot #(
    .DIV_CICLOS (DIV_CICLOS)
  ) u_contador_slot (
    .clk     (clock),
    .rst     (reset),
    .i_conta (w_conta),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // Scan state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= PARADO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next scan state: enable low always wins, otherwise blank/lit per slot.
  always_comb begin
    w_estado_prox = r_estado;
    if (!bus.enable) begin
      w_estado_prox = PARADO;
    end else begin
      case (r_estado)
        PARADO:  w_estado_prox = c_INICIO;
        APAGADO: begin
          if (w_tc) begin
            w_estado_prox = c_INICIO;
          end else if (w_cnt == c_BLANK_FIM) begin
            w_estado_prox = ACESO;
          end
        end
        ACESO: begin
          if (w_tc) begin
            w_estado_prox = c_INICIO;
          end
        end
        default: w_estado_prox = PARADO;
      endcase
    end
  end

  // Row counter: advances at slot end, wraps after row 5, clears when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lin <= '0;
    end else if (!bus.enable || !w_rodando) begin
      r_lin <= '0;
    end else if (w_tc) begin
      r_lin <= w_ultima ? 3'd0 : r_lin + 3'd1;
    end
  end

  // Shadow frame: captured only on entry to row 0 so a scan never tears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quadro <= '0;
    end else if (bus.enable && (!w_rodando || (w_tc && w_ultima))) begin
      r_quadro <= bus.leds;
    end
  end

  // Pin decode from registered state only.
  always_comb begin
    bus.linhas     = '0;
    bus.colunas    = '0;
    bus.fim_quadro = w_rodando && w_tc && w_ultima;
    if (r_estado == ACESO) begin
      bus.linhas  = 6'b000001 << r_lin;
      bus.colunas = r_quadro[indice(r_lin, 3'd0) +: COLUNAS];
    end
  end

endmodule
`default_nettype wire
